// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 decrypt engine: FSM state encoding
// and the plaintext character filter used by the early-abort key check.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    KSA_RD_I,
    KSA_CAP_I,
    KSA_WR_I,
    KSA_WR_J,
    PR_INC,
    PR_CAP_I,
    PR_WR_I,
    PR_WR_J,
    PR_RD_F,
    PR_CAP_F,
    DONE
  } state_e;

  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  // Lower-case letters and space are the only characters a correct key yields.
  function automatic logic is_valid_char(input logic [7:0] c);
    return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
  endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Selects key byte (idx mod KEY_BYTES) from the latched key; byte 0 sits in
// the most significant position of the key vector.
module rc4_key_byte_sel #(
  parameter int KEY_BYTES = 3
) (
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  logic [7:0]             idx_i,
  output logic [7:0]             byte_o
);

  localparam logic [7:0] KB = 8'(KEY_BYTES);

  logic [7:0] sel;

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    sel    = idx_i % KB;
    byte_o = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (sel == 8'(n)) byte_o = key_i[8*(KEY_BYTES-n)-1 -: 8];
    end
  end

endmodule

// File: rtl/rc4_decrypt_core.sv
// Single-FSM RC4 decryptor: S-array init, key scheduling and PRGA/XOR share
// one S-memory port; optional per-byte plaintext check ends a bad key early.
module rc4_decrypt_core
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int CHECK_EN  = 1,
  localparam int AW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   key_ok,
  output logic [7:0]             fail_idx,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rddata,
  output logic [AW-1:0]          em_addr,
  input  logic [7:0]             em_rddata,
  output logic [AW-1:0]          dm_addr,
  output logic [7:0]             dm_wrdata,
  output logic                   dm_wren
);

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_e                 state_q, state_d;
  logic [7:0]             i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0]             si_q, si_d, sj_q, sj_d, em_q, em_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic                   key_ok_q, key_ok_d;
  logic [7:0]             fail_idx_q, fail_idx_d;
  logic [7:0]             key_byte;
  logic [7:0]             p;

  rc4_key_byte_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .key_i  (key_q),
    .idx_i  (i_q),
    .byte_o (key_byte)
  );

  assign key_ok   = key_ok_q;
  assign fail_idx = fail_idx_q;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    em_d       = em_q;
    key_d      = key_q;
    key_ok_d   = key_ok_q;
    fail_idx_d = fail_idx_q;
    s_addr     = '0;
    s_wrdata   = '0;
    s_wren     = 1'b0;
    em_addr    = '0;
    dm_addr    = '0;
    dm_wrdata  = '0;
    dm_wren    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    p          = s_rddata ^ em_q;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          key_d      = key;
          key_ok_d   = 1'b0;
          fail_idx_d = '0;
          i_d        = '0;
          state_d    = INIT;
        end
      end
      INIT: begin
        s_addr   = i_q;
        s_wrdata = i_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          j_d     = '0;
          state_d = KSA_RD_I;
        end
      end
      KSA_RD_I: begin
        s_addr  = i_q;
        state_d = KSA_CAP_I;
      end
      KSA_CAP_I: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata + key_byte;
        s_addr  = j_d;
        state_d = KSA_WR_I;
      end
      KSA_WR_I: begin
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = KSA_WR_J;
      end
      KSA_WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        state_d  = KSA_RD_I;
        if (i_q == 8'hFF) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = PR_INC;
        end
      end
      PR_INC: begin
        i_d     = i_q + 8'd1;
        s_addr  = i_d;
        em_addr = k_q[AW-1:0];
        state_d = PR_CAP_I;
      end
      PR_CAP_I: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        s_addr  = j_d;
        em_d    = em_rddata;
        state_d = PR_WR_I;
      end
      PR_WR_I: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = PR_WR_J;
      end
      PR_WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = PR_RD_F;
      end
      PR_RD_F: begin
        s_addr  = si_q + sj_q;
        state_d = PR_CAP_F;
      end
      PR_CAP_F: begin
        if ((CHECK_EN == 0) || is_valid_char(p)) begin
          dm_addr   = k_q[AW-1:0];
          dm_wrdata = p;
          dm_wren   = 1'b1;
          if (k_q == LAST_K) begin
            key_ok_d = 1'b1;
            state_d  = DONE;
          end else begin
            k_d     = k_q + 8'd1;
            state_d = PR_INC;
          end
        end else begin
          fail_idx_d = k_q;
          key_ok_d   = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Cancel suppresses this cycle's writes as well, so nothing lands after abort.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      s_wren     = 1'b0;
      dm_wren    = 1'b0;
      key_ok_d   = key_ok_q;
      fail_idx_d = fail_idx_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      em_q       <= '0;
      key_q      <= '0;
      key_ok_q   <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      em_q       <= em_d;
      key_q      <= key_d;
      key_ok_q   <= key_ok_d;
      fail_idx_q <= fail_idx_d;
    end
  end

endmodule
